cache_bus_sram_responder: RTL and testbench
===========================================

// Module: cache_bus_sram_responder
// PURPOSE
//  Target (slave) end of the cache bus: accepts cache_bus_req_t requests from an
//  initiator (icache/dcache refill, uncached passthrough) and answers with
//  cache_bus_resp_t from an on-chip synchronous SRAM. Serves as boot/scratch memory
//  behind the bus arbiter and as the bench memory model for cache verification.
// PARAMETERS
//  MEM_WORDS   4096  SRAM depth in 32-bit words (power of two)
//  AW          $clog2(MEM_WORDS)  word-address width (derived, do not override)
// PORTS
//  clk          in   1                 clock
//  rst_n        in   1                 synchronous reset, active low
//  bus_req_i    in   cache_bus_req_t   initiator request/data-phase signals
//  bus_resp_o   out  cache_bus_resp_t  ready / data_ok / data_last / r_data
//  busy_o       out  1                 transaction in flight (feeds bus_busy_i)
//  proto_err_o  out  1                 sticky burst-length mismatch flag
// BEHAVIOUR
//  - One clock; reset synchronous, active low. In reset: FSM=IDLE, bus_resp_o='0,
//    busy_o=0, proto_err_o=0. SRAM contents are not cleared.
//  - FSM: IDLE -> RD | WR -> IDLE. Reset mid-burst aborts to IDLE; no beat is emitted.
//  - IDLE: resp.ready=1. Handshake = req.valid && resp.ready. On handshake latch:
//    word addr = req.addr[AW+1:2], beats = req.burst_size+1 (1..16), write flag.
//    Go to RD or WR on the next cycle. resp.ready=0 in RD/WR.
//  - RD: SRAM read latency 1. First resp.data_ok no earlier than 2 cycles after the
//    handshake. resp.data_ok = beat_ready && req.data_ok; beat advances only then.
//    With req.data_ok held high: 1 beat/cycle. req.data_ok low: current beat and
//    r_data held, no loss/duplication. r_data is always the full word.
//    resp.data_last=1 together with data_ok on the final beat; next cycle IDLE.
//  - WR: beat accepted in any cycle with req.data_ok=1; resp.data_ok=1 in that same
//    cycle. Bytes written per req.data_strobe[i] -> byte i of w_data.
//    resp.data_last=1 on the beat completing the count.
//  - Burst address increments by one word per beat, wraps modulo MEM_WORDS.
//    Upper addr bits above AW+1 ignored; data_size and cached ignored.
//  - Length mismatch on write: req.data_last before count exhausted -> end burst
//    after that beat, go IDLE, set proto_err_o. Count exhausted without
//    req.data_last -> also set proto_err_o. proto_err_o is cleared only by reset.
//  - busy_o = (FSM != IDLE); high from the cycle after the handshake through the
//    final beat.
//  - New request arriving while busy: initiator holds req.valid; it is accepted
//    on the first IDLE cycle.
// CONFIGURATION
//  CBUS_RESP_STALL_EN defined: 16-bit LFSR x^16+x^14+x^13+x^11+1, seed 16'hACE1
//    after reset, steps every cycle. resp.ready and resp.data_ok are masked while
//    lfsr[0]==0. Beats and handshakes are delayed only, never dropped.
//  Undefined: no masking; timing exactly as above.
// TESTING
//  1 Hold rst_n=0 for 3 clk, then release -> bus_resp_o=0 during reset;
//    ready=1, busy_o=0 on the first cycle after release.
//  2 Write burst_size=4'b0011, addr 32'h1C000100, strobe 4'hF, data
//    32'hA0..32'hA3, data_last on beat 4. Then read the same burst with
//    req.data_ok=1 -> 4 consecutive data_ok with A0,A1,A2,A3; data_last on the 4th;
//    first beat 2 cycles after the handshake.
//  3 Single-beat write 32'h11223344 to addr 32'h200, then write 32'hAABBCCDD with
//    strobe 4'b0011. Single-beat read -> r_data=32'h1122CCDD, data_ok and data_last
//    in the same cycle.
//  4 4-beat read; req.data_ok pattern 1,0,0,1,1,0,1 -> exactly 4 beats in order,
//    none while req.data_ok=0, busy_o drops after the last beat.
//  5 4-beat read at word MEM_WORDS-2 -> beats from words MEM_WORDS-2, MEM_WORDS-1,
//    0, 1.
//  6 4-beat write with req.data_last on beat 2 -> FSM IDLE next cycle, ready=1,
//    proto_err_o=1 and held until reset. Repeat tests 2-5 with CBUS_RESP_STALL_EN
//    defined -> identical data results.

Source files
------------

// File: rtl/cache_bus_sram_responder.sv
// Cache-bus target backed by a synchronous single-port SRAM (read latency 1, byte-strobed writes).
// Optional macro CBUS_RESP_STALL_EN: LFSR-driven masking of resp.ready / resp.data_ok.
package cache_bus_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [3:0]  burst_size;
        logic [1:0]  data_size;
        logic        cached;
        logic        data_ok;
        logic        data_last;
        logic [3:0]  data_strobe;
        logic [31:0] w_data;
    } cache_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic        data_ok;
        logic        data_last;
        logic [31:0] r_data;
    } cache_bus_resp_t;
endpackage

module cache_bus_sram_responder
    import cache_bus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  cache_bus_req_t  bus_req_i,
    output cache_bus_resp_t bus_resp_o,
    output logic            busy_o,
    output logic            proto_err_o
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [4:0]    beats_q, beats_d;
    logic          beat_vld_q, beat_vld_d;
    logic          perr_q, perr_d;
    logic [31:0]   rd_data_q;
    logic [31:0]   mem [MEM_WORDS];

    logic stall_ok;
    logic ready;
    logic hs;
    logic rd_take;
    logic wr_take;
    logic last_beat;
    logic rd_en;

    logic unused_req_bits;
    assign unused_req_bits = ^{bus_req_i.data_size, bus_req_i.cached,
                               bus_req_i.addr[31:AW+2], bus_req_i.addr[1:0]};

`ifdef CBUS_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_ok = lfsr_q[0];
`else
    assign stall_ok = 1'b1;
`endif

    // ready is gated by rst_n so the response bus stays all-zero while reset is held.
    assign ready     = rst_n && (state_q == ST_IDLE) && stall_ok;
    assign hs        = bus_req_i.valid && ready;
    assign last_beat = (beats_q == 5'd1);
    assign rd_take   = (state_q == ST_RD) && beat_vld_q && bus_req_i.data_ok && stall_ok;
    assign wr_take   = (state_q == ST_WR) && bus_req_i.data_ok && stall_ok;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beats_d    = beats_q;
        beat_vld_d = beat_vld_q;
        perr_d     = perr_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    addr_d     = bus_req_i.addr[AW+1:2];
                    beats_d    = {1'b0, bus_req_i.burst_size} + 5'd1;
                    beat_vld_d = 1'b0;
                    state_d    = bus_req_i.write ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                beat_vld_d = 1'b1;
                if (rd_take) begin
                    if (last_beat) begin
                        state_d    = ST_IDLE;
                        beat_vld_d = 1'b0;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        beats_d = beats_q - 5'd1;
                    end
                end
            end
            ST_WR: begin
                if (wr_take) begin
                    addr_d  = addr_q + 1'b1;
                    beats_d = beats_q - 5'd1;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        perr_d  = perr_q | ~bus_req_i.data_last;
                    end else if (bus_req_i.data_last) begin
                        state_d = ST_IDLE;
                        perr_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Prefetch the following word while the current one is taken, giving one beat per cycle.
    assign rd_en = (state_q == ST_RD) && (!beat_vld_q || (rd_take && !last_beat));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            beats_q    <= '0;
            beat_vld_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beats_q    <= beats_d;
            beat_vld_q <= beat_vld_d;
            perr_q     <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[addr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_take) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus_req_i.data_strobe[i]) begin
                    mem[addr_q][8*i +: 8] <= bus_req_i.w_data[8*i +: 8];
                end
            end
        end
    end

    assign bus_resp_o.ready     = ready;
    assign bus_resp_o.data_ok   = rd_take || wr_take;
    assign bus_resp_o.data_last = (rd_take || wr_take) && last_beat;
    assign bus_resp_o.r_data    = rd_data_q;
    assign busy_o               = (state_q != ST_IDLE);
    assign proto_err_o          = perr_q;

endmodule

// File: tb/tb_cache_bus_sram_responder.sv
// Directed bench for cache_bus_sram_responder with a transaction-level memory model checked every cycle.
module tb_cache_bus_sram_responder;
    import cache_bus_pkg::*;

    localparam int MW = 4096;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    cache_bus_req_t  req;
    cache_bus_resp_t resp;
    logic            busy;
    logic            perr;

    cache_bus_sram_responder #(.MEM_WORDS(MW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_req_i   (req),
        .bus_resp_o  (resp),
        .busy_o      (busy),
        .proto_err_o (perr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: memory image plus the outstanding burst's kind, address and beats left.
    logic [31:0] m_mem [MW];
    int          m_kind = 0;   // 0 none, 1 read, 2 write
    int          m_addr = 0;
    int          m_left = 0;
    int          m_age  = 0;
    bit          m_perr = 1'b0;
    bit          rst_hit = 1'b0;

    always @(posedge clk) rst_hit = !rst_n;

    always @(negedge clk) begin
        if (rst_hit) begin
            m_kind = 0;
            m_perr = 1'b0;
        end
        if (!rst_n) begin
            if (rst_hit) begin
                chk("rst_ctl", 32'({resp.ready, resp.data_ok, resp.data_last, busy, perr}), 32'd0);
                chk("rst_rdata", resp.r_data, 32'd0);
            end
        end else begin
            chk("busy", 32'(busy), 32'(m_kind != 0));
            chk("proto_err", 32'(perr), 32'(m_perr));
            if (m_kind != 0) chk("ready_busy", 32'(resp.ready), 32'd0);
`ifndef CBUS_RESP_STALL_EN
            else chk("ready_idle", 32'(resp.ready), 32'd1);
`endif
            if (m_kind == 1) begin
                m_age++;
`ifdef CBUS_RESP_STALL_EN
                if (resp.data_ok) chk("rd_gate", 32'(req.data_ok && m_age >= 2), 32'd1);
`else
                chk("rd_ok", 32'(resp.data_ok), 32'(req.data_ok && m_age >= 2));
`endif
                if (resp.data_ok) begin
                    chk("rd_data", resp.r_data, m_mem[m_addr]);
                    chk("rd_last", 32'(resp.data_last), 32'(m_left == 1));
                    m_addr = (m_addr + 1) % MW;
                    m_left--;
                    if (m_left == 0) m_kind = 0;
                end
            end else if (m_kind == 2) begin
`ifdef CBUS_RESP_STALL_EN
                if (resp.data_ok) chk("wr_gate", 32'(req.data_ok), 32'd1);
`else
                chk("wr_ok", 32'(resp.data_ok), 32'(req.data_ok));
`endif
                if (resp.data_ok) begin
                    chk("wr_last", 32'(resp.data_last), 32'(m_left == 1));
                    for (int b = 0; b < 4; b++)
                        if (req.data_strobe[b]) m_mem[m_addr][8*b +: 8] = req.w_data[8*b +: 8];
                    m_addr = (m_addr + 1) % MW;
                    if (m_left == 1) begin
                        if (!req.data_last) m_perr = 1'b1;
                        m_kind = 0;
                    end else if (req.data_last) begin
                        m_perr = 1'b1;
                        m_kind = 0;
                    end else begin
                        m_left--;
                    end
                end
            end else begin
                chk("idle_ok", 32'(resp.data_ok), 32'd0);
                if (req.valid && resp.ready) begin
                    m_kind = req.write ? 2 : 1;
                    m_addr = int'((req.addr >> 2) % MW);
                    m_left = int'(req.burst_size) + 1;
                    m_age  = 0;
                end
            end
        end
    end

    logic [31:0] got_d [$];
    bit          got_l [$];
    int          lat;

    task automatic handshake(input logic [31:0] a, input logic [3:0] bs, input logic wr);
        req.valid      = 1'b1;
        req.addr       = a;
        req.burst_size = bs;
        req.write      = wr;
        req.data_size  = 2'd2;
        req.cached     = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (resp.ready) break;
        end
        chk("hs_ready", 32'(resp.ready), 32'd1);
        @(posedge clk); #1;
        req.valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] bs, input int nsend,
                            input int last_at, input logic [31:0] base, input logic [3:0] strb);
        handshake(a, bs, 1'b1);
        for (int i = 0; i < nsend; i++) begin
            req.data_ok     = 1'b1;
            req.w_data      = base + 32'(i);
            req.data_strobe = strb;
            req.data_last   = (i + 1 == last_at);
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (resp.data_ok) break;
            end
            chk("wr_beat_seen", 32'(resp.data_ok), 32'd1);
            @(posedge clk); #1;
        end
        req.data_ok   = 1'b0;
        req.data_last = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] bs,
                           input logic [15:0] pat, input int plen);
        bit done = 1'b0;
        got_d.delete();
        got_l.delete();
        lat = -1;
        handshake(a, bs, 1'b0);
        for (int j = 1; j <= 100 && !done; j++) begin
            req.data_ok = (j <= plen) ? pat[j-1] : 1'b1;
            @(negedge clk);
            if (resp.data_ok) begin
                got_d.push_back(resp.r_data);
                got_l.push_back(resp.data_last);
                if (lat < 0) lat = j;
                if (resp.data_last) done = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("rd_done", 32'(done), 32'd1);
        req.data_ok = 1'b0;
    endtask

    task automatic chk_beats(input int n, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk("beat_count", 32'(got_d.size()), 32'(n));
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            chk("beat_data", got_d[i], e[i]);
            chk("beat_last", 32'(got_l[i]), 32'(i == n - 1));
        end
    endtask

    initial begin
        req   = '0;
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_hold", 32'({resp.ready, resp.data_ok, resp.data_last, busy, perr}), 32'd0);
        end
        rst_n = 1'b1;
        #1;
`ifndef CBUS_RESP_STALL_EN
        chk("post_rst_ready", 32'(resp.ready), 32'd1);
`endif
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // 4-beat write then read back
        do_write(32'h1C000100, 4'd3, 4, 4, 32'hA0, 4'hF);
        do_read(32'h1C000100, 4'd3, 16'hFFFF, 16);
        chk_beats(4, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
`ifndef CBUS_RESP_STALL_EN
        chk("rd_latency", 32'(lat), 32'd2);
`endif

        // byte strobes
        do_write(32'h200, 4'd0, 1, 1, 32'h11223344, 4'hF);
        do_write(32'h200, 4'd0, 1, 1, 32'hAABBCCDD, 4'b0011);
        do_read(32'h200, 4'd0, 16'hFFFF, 16);
        chk_beats(1, 32'h1122CCDD, 32'h0, 32'h0, 32'h0);

        // initiator throttling: data_ok 0 in the wait cycle, then 1,0,0,1,1,0,1
        do_read(32'h1C000100, 4'd3, 16'h00B2, 8);
        chk_beats(4, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        chk("busy_after_rd", 32'(busy), 32'd0);

        // address wrap at the top of memory
        do_write(32'h3FF8, 4'd0, 1, 1, 32'hD0, 4'hF);
        do_write(32'h3FFC, 4'd0, 1, 1, 32'hD1, 4'hF);
        do_write(32'h0000, 4'd0, 1, 1, 32'hD2, 4'hF);
        do_write(32'h0004, 4'd0, 1, 1, 32'hD3, 4'hF);
        do_read(32'h3FF8, 4'd3, 16'hFFFF, 16);
        chk_beats(4, 32'hD0, 32'hD1, 32'hD2, 32'hD3);

        // early data_last on a 4-beat write
        do_write(32'h300, 4'd3, 2, 2, 32'hE0, 4'hF);
`ifndef CBUS_RESP_STALL_EN
        chk("early_last_ready", 32'(resp.ready), 32'd1);
`endif
        chk("early_last_busy", 32'(busy), 32'd0);
        chk("early_last_perr", 32'(perr), 32'd1);
        repeat (5) begin @(posedge clk); #1; end
        chk("perr_sticky", 32'(perr), 32'd1);

        // reset in the middle of a read burst
        handshake(32'h1C000100, 4'd15, 1'b0);
        req.data_ok = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n       = 1'b0;
        req.data_ok = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_perr", 32'(perr), 32'd0);
        rst_n       = 1'b1;
        req.data_ok = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        req.data_ok = 1'b0;

        // count exhausted without data_last
        do_write(32'h400, 4'd1, 2, 0, 32'hF0, 4'hF);
        chk("no_last_perr", 32'(perr), 32'd1);
        chk("no_last_busy", 32'(busy), 32'd0);
        do_read(32'h400, 4'd1, 16'hFFFF, 16);
        chk_beats(2, 32'hF0, 32'hF1, 32'h0, 32'h0);

        repeat (2) begin @(posedge clk); #1; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required earlier finish", $time);
        $fatal(1);
    end

endmodule
